id_ex_stage: RTL and testbench

- ID/EX pipeline register for the five-stage RV32I core.
- Sits directly downstream of the register file. Captures r1_data/r2_data, the immediate and the decoded control for the instruction in ID, and presents them to EX.
- Contains load-use hazard detection. Inserts a one-cycle bubble on a hazard and drives stall upstream to PC/IF-ID.
- Handles branch flush and keeps a saturating bubble counter for performance debug.

---
 rtl/id_ex_stage.sv | 194 +++++++++++++++++++
 tb/tb_id_ex_stage.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the five-stage RV32I core.
// Latches operands, immediate and decoded control from ID into EX, detects
// load-use hazards against the instruction currently in EX, inserts a single
// bubble per hazard, honours branch flush, and counts hazard bubbles.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic [XLEN-1:0] id_r1_data,
  input  logic [XLEN-1:0] id_r2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [3:0]      id_alu_op,
  input  logic            id_alu_src,
  input  logic            id_mem_rd,
  input  logic            id_mem_wr,
  input  logic            id_reg_wr,
  input  logic [1:0]      id_wb_sel,
  input  logic [2:0]      id_funct3,
  input  logic            flush,
  output logic            stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [XLEN-1:0] ex_r1_data,
  output logic [XLEN-1:0] ex_r2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [3:0]      ex_alu_op,
  output logic            ex_alu_src,
  output logic            ex_mem_rd,
  output logic            ex_mem_wr,
  output logic            ex_reg_wr,
  output logic [1:0]      ex_wb_sel,
  output logic [2:0]      ex_funct3,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic            ex_valid_q,   ex_valid_d;
  logic [XLEN-1:0] ex_pc_q,      ex_pc_d;
  logic [4:0]      ex_rs1_q,     ex_rs1_d;
  logic [4:0]      ex_rs2_q,     ex_rs2_d;
  logic [4:0]      ex_rd_q,      ex_rd_d;
  logic [XLEN-1:0] ex_r1_data_q, ex_r1_data_d;
  logic [XLEN-1:0] ex_r2_data_q, ex_r2_data_d;
  logic [XLEN-1:0] ex_imm_q,     ex_imm_d;
  logic [3:0]      ex_alu_op_q,  ex_alu_op_d;
  logic            ex_alu_src_q, ex_alu_src_d;
  logic            ex_mem_rd_q,  ex_mem_rd_d;
  logic            ex_mem_wr_q,  ex_mem_wr_d;
  logic            ex_reg_wr_q,  ex_reg_wr_d;
  logic [1:0]      ex_wb_sel_q,  ex_wb_sel_d;
  logic [2:0]      ex_funct3_q,  ex_funct3_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  logic hit_rs1_s;
  logic hit_rs2_s;
  logic stall_s;

  // Load-use hazard: a load in EX writes a register the ID instruction reads.
  always_comb begin
    hit_rs1_s = id_use_rs1 & (id_rs1 == ex_rd_q);
    hit_rs2_s = id_use_rs2 & (id_rs2 == ex_rd_q);
    stall_s   = id_valid & ex_valid_q & ex_mem_rd_q & (ex_rd_q != 5'd0)
              & (hit_rs1_s | hit_rs2_s);
  end

  // Next EX contents: flush beats stall; both load a bubble, only stall counts.
  always_comb begin
    ex_valid_d   = 1'b0;
    ex_pc_d      = {XLEN{1'b0}};
    ex_rs1_d     = 5'd0;
    ex_rs2_d     = 5'd0;
    ex_rd_d      = 5'd0;
    ex_r1_data_d = {XLEN{1'b0}};
    ex_r2_data_d = {XLEN{1'b0}};
    ex_imm_d     = {XLEN{1'b0}};
    ex_alu_op_d  = 4'd0;
    ex_alu_src_d = 1'b0;
    ex_mem_rd_d  = 1'b0;
    ex_mem_wr_d  = 1'b0;
    ex_reg_wr_d  = 1'b0;
    ex_wb_sel_d  = 2'd0;
    ex_funct3_d  = 3'd0;
    bubble_cnt_d = bubble_cnt_q;
    if (flush) begin
      bubble_cnt_d = bubble_cnt_q;
    end else if (stall_s) begin
      if (bubble_cnt_q != CNT_MAX) begin
        bubble_cnt_d = bubble_cnt_q + CNT_ONE;
      end else begin
        bubble_cnt_d = bubble_cnt_q;
      end
    end else begin
      // Data, indices and PC follow ID regardless of validity; control is
      // gated so an empty slot can never cause a side effect in EX/MEM/WB.
      ex_valid_d   = id_valid;
      ex_pc_d      = id_pc;
      ex_rs1_d     = id_rs1;
      ex_rs2_d     = id_rs2;
      ex_rd_d      = id_rd;
      ex_r1_data_d = id_r1_data;
      ex_r2_data_d = id_r2_data;
      ex_imm_d     = id_imm;
      if (id_valid) begin
        ex_alu_op_d  = id_alu_op;
        ex_alu_src_d = id_alu_src;
        ex_mem_rd_d  = id_mem_rd;
        ex_mem_wr_d  = id_mem_wr;
        ex_reg_wr_d  = id_reg_wr & (id_rd != 5'd0);
        ex_wb_sel_d  = id_wb_sel;
        ex_funct3_d  = id_funct3;
      end else begin
        ex_alu_op_d  = 4'd0;
        ex_alu_src_d = 1'b0;
        ex_mem_rd_d  = 1'b0;
        ex_mem_wr_d  = 1'b0;
        ex_reg_wr_d  = 1'b0;
        ex_wb_sel_d  = 2'd0;
        ex_funct3_d  = 3'd0;
      end
    end
  end

  // Pipeline register and bubble counter, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q   <= 1'b0;
      ex_pc_q      <= {XLEN{1'b0}};
      ex_rs1_q     <= 5'd0;
      ex_rs2_q     <= 5'd0;
      ex_rd_q      <= 5'd0;
      ex_r1_data_q <= {XLEN{1'b0}};
      ex_r2_data_q <= {XLEN{1'b0}};
      ex_imm_q     <= {XLEN{1'b0}};
      ex_alu_op_q  <= 4'd0;
      ex_alu_src_q <= 1'b0;
      ex_mem_rd_q  <= 1'b0;
      ex_mem_wr_q  <= 1'b0;
      ex_reg_wr_q  <= 1'b0;
      ex_wb_sel_q  <= 2'd0;
      ex_funct3_q  <= 3'd0;
      bubble_cnt_q <= {CNT_W{1'b0}};
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_pc_q      <= ex_pc_d;
      ex_rs1_q     <= ex_rs1_d;
      ex_rs2_q     <= ex_rs2_d;
      ex_rd_q      <= ex_rd_d;
      ex_r1_data_q <= ex_r1_data_d;
      ex_r2_data_q <= ex_r2_data_d;
      ex_imm_q     <= ex_imm_d;
      ex_alu_op_q  <= ex_alu_op_d;
      ex_alu_src_q <= ex_alu_src_d;
      ex_mem_rd_q  <= ex_mem_rd_d;
      ex_mem_wr_q  <= ex_mem_wr_d;
      ex_reg_wr_q  <= ex_reg_wr_d;
      ex_wb_sel_q  <= ex_wb_sel_d;
      ex_funct3_q  <= ex_funct3_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall      = stall_s;
  assign ex_valid   = ex_valid_q;
  assign ex_pc      = ex_pc_q;
  assign ex_rs1     = ex_rs1_q;
  assign ex_rs2     = ex_rs2_q;
  assign ex_rd      = ex_rd_q;
  assign ex_r1_data = ex_r1_data_q;
  assign ex_r2_data = ex_r2_data_q;
  assign ex_imm     = ex_imm_q;
  assign ex_alu_op  = ex_alu_op_q;
  assign ex_alu_src = ex_alu_src_q;
  assign ex_mem_rd  = ex_mem_rd_q;
  assign ex_mem_wr  = ex_mem_wr_q;
  assign ex_reg_wr  = ex_reg_wr_q;
  assign ex_wb_sel  = ex_wb_sel_q;
  assign ex_funct3  = ex_funct3_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: a default-width instance plus a
// CNT_W=4 instance on the same stimulus for the counter saturation case.
module tb_id_ex_stage;

  localparam int EW = 157;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic        id_valid, id_use_rs1, id_use_rs2, id_alu_src, id_mem_rd, id_mem_wr, id_reg_wr, flush;
  logic [31:0] id_pc, id_r1_data, id_r2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_alu_op;
  logic [1:0]  id_wb_sel;
  logic [2:0]  id_funct3;

  logic        stall, ex_valid, ex_alu_src, ex_mem_rd, ex_mem_wr, ex_reg_wr;
  logic [31:0] ex_pc, ex_r1_data, ex_r2_data, ex_imm, bubble_cnt;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [3:0]  ex_alu_op;
  logic [1:0]  ex_wb_sel;
  logic [2:0]  ex_funct3;

  logic        s_stall, s_valid, s_alu_src, s_mem_rd, s_mem_wr, s_reg_wr;
  logic [31:0] s_pc, s_r1_data, s_r2_data, s_imm;
  logic [3:0]  s_bubble_cnt;
  logic [4:0]  s_rs1, s_rs2, s_rd;
  logic [3:0]  s_alu_op;
  logic [1:0]  s_wb_sel;
  logic [2:0]  s_funct3;

  typedef struct packed {
    logic [EW-1:0] ex;
    logic [31:0]   cnt;
    logic [3:0]    cnt4;
    logic          v;
    logic [4:0]    rd;
    logic          mr;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int failed = 0;
  logic        m_valid = 1'b0;
  logic [4:0]  m_rd = 5'd0;
  logic        m_mr = 1'b0;
  logic [31:0] m_cnt = 32'd0;
  logic [3:0]  m_cnt4 = 4'd0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_r1_data(id_r1_data),
    .id_r2_data(id_r2_data), .id_imm(id_imm), .id_alu_op(id_alu_op), .id_alu_src(id_alu_src),
    .id_mem_rd(id_mem_rd), .id_mem_wr(id_mem_wr), .id_reg_wr(id_reg_wr), .id_wb_sel(id_wb_sel),
    .id_funct3(id_funct3), .flush(flush), .stall(stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_r1_data(ex_r1_data), .ex_r2_data(ex_r2_data),
    .ex_imm(ex_imm), .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_mem_rd(ex_mem_rd),
    .ex_mem_wr(ex_mem_wr), .ex_reg_wr(ex_reg_wr), .ex_wb_sel(ex_wb_sel), .ex_funct3(ex_funct3),
    .bubble_cnt(bubble_cnt));

  id_ex_stage #(.XLEN(32), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_r1_data(id_r1_data),
    .id_r2_data(id_r2_data), .id_imm(id_imm), .id_alu_op(id_alu_op), .id_alu_src(id_alu_src),
    .id_mem_rd(id_mem_rd), .id_mem_wr(id_mem_wr), .id_reg_wr(id_reg_wr), .id_wb_sel(id_wb_sel),
    .id_funct3(id_funct3), .flush(flush), .stall(s_stall), .ex_valid(s_valid), .ex_pc(s_pc),
    .ex_rs1(s_rs1), .ex_rs2(s_rs2), .ex_rd(s_rd), .ex_r1_data(s_r1_data), .ex_r2_data(s_r2_data),
    .ex_imm(s_imm), .ex_alu_op(s_alu_op), .ex_alu_src(s_alu_src), .ex_mem_rd(s_mem_rd),
    .ex_mem_wr(s_mem_wr), .ex_reg_wr(s_reg_wr), .ex_wb_sel(s_wb_sel), .ex_funct3(s_funct3),
    .bubble_cnt(s_bubble_cnt));

  function automatic logic [EW-1:0] act_vec();
    return {ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_r1_data, ex_r2_data, ex_imm,
            ex_alu_op, ex_alu_src, ex_mem_rd, ex_mem_wr, ex_reg_wr, ex_wb_sel, ex_funct3};
  endfunction

  function automatic logic [EW-1:0] act_vec4();
    return {s_valid, s_pc, s_rs1, s_rs2, s_rd, s_r1_data, s_r2_data, s_imm,
            s_alu_op, s_alu_src, s_mem_rd, s_mem_wr, s_reg_wr, s_wb_sel, s_funct3};
  endfunction

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic u1, input logic u2, input logic [31:0] r1,
                        input logic [31:0] r2, input logic [31:0] imm, input logic [3:0] op,
                        input logic src, input logic mr, input logic mw, input logic rw,
                        input logic [1:0] wb, input logic [2:0] f3);
    id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_use_rs1 = u1; id_use_rs2 = u2;
    id_r1_data = r1; id_r2_data = r2; id_imm = imm; id_alu_op = op; id_alu_src = src;
    id_mem_rd = mr; id_mem_wr = mw; id_reg_wr = rw; id_wb_sel = wb; id_funct3 = f3;
  endtask

  task automatic id_idle();
    set_id(1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0);
    flush = 1'b0;
  endtask

  // lw rd, imm(rs1)
  task automatic set_load(input logic [4:0] rd, input logic [4:0] rs1);
    set_id(1'b1, 32'h0000_1000, rs1, 5'd0, rd, 1'b1, 1'b0, 32'h0000_2000, 32'd0, 32'd4, 4'd0, 1'b1,
           1'b1, 1'b0, 1'b1, 2'd1, 3'b010);
  endtask

  // add rd, rs1, rs2
  task automatic set_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    set_id(1'b1, 32'h0000_1004, rs1, rs2, rd, 1'b1, 1'b1, 32'h1111_1111, 32'h2222_2222, 32'd0, 4'd0,
           1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 3'b000);
  endtask

  // One clock: check stall, push the expected EX state, clock, pop and compare.
  task automatic cycle(input string name);
    logic exp_stall;
    exp_t e;
    #1;
    exp_stall = id_valid & m_valid & m_mr & (m_rd != 5'd0)
              & ((id_use_rs1 & (id_rs1 == m_rd)) | (id_use_rs2 & (id_rs2 == m_rd)));
    tests++;
    if ({stall, s_stall} !== {exp_stall, exp_stall}) begin
      failed++;
      $display("FAIL %s stall: got %b/%b want %b", name, stall, s_stall, exp_stall);
    end
    e = '0;
    e.cnt = m_cnt;
    e.cnt4 = m_cnt4;
    if (!flush && exp_stall) begin
      if (m_cnt != 32'hFFFF_FFFF) e.cnt = m_cnt + 32'd1;
      if (m_cnt4 != 4'hF) e.cnt4 = m_cnt4 + 4'd1;
    end
    if (!flush && !exp_stall) begin
      e.ex = {id_valid, id_pc, id_rs1, id_rs2, id_rd, id_r1_data, id_r2_data, id_imm,
              id_valid ? id_alu_op : 4'd0, id_alu_src & id_valid, id_mem_rd & id_valid,
              id_mem_wr & id_valid, id_reg_wr & id_valid & (id_rd != 5'd0),
              id_valid ? id_wb_sel : 2'd0, id_valid ? id_funct3 : 3'd0};
      e.v = id_valid;
      e.rd = id_rd;
      e.mr = id_mem_rd & id_valid;
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    tests++;
    if (act_vec() !== e.ex || act_vec4() !== e.ex) begin
      failed++;
      $display("FAIL %s ex: got %h want %h", name, act_vec(), e.ex);
    end
    tests++;
    if (bubble_cnt !== e.cnt || s_bubble_cnt !== e.cnt4) begin
      failed++;
      $display("FAIL %s bubble_cnt: got %0d/%0d want %0d/%0d", name, bubble_cnt, s_bubble_cnt, e.cnt, e.cnt4);
    end
    m_valid = e.v; m_rd = e.rd; m_mr = e.mr; m_cnt = e.cnt; m_cnt4 = e.cnt4;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    id_idle();
    q.delete();
    m_valid = 1'b0; m_rd = 5'd0; m_mr = 1'b0; m_cnt = 32'd0; m_cnt4 = 4'd0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    id_idle();
    #1;
    tests++;
    if (act_vec() !== '0 || bubble_cnt !== 32'd0 || stall !== 1'b0) begin
      failed++;
      $display("FAIL reset_initial: ex %h cnt %0d stall %b want all 0", act_vec(), bubble_cnt, stall);
    end
    do_reset();
    set_load(5'd7, 5'd1);  cycle("rst_load");
    set_add(5'd3, 5'd2, 5'd7); cycle("rst_stall");
    cycle("rst_add");
    set_load(5'd7, 5'd1);  cycle("rst_load2");
    set_add(5'd3, 5'd7, 5'd2);
    #2;
    tests++;
    if (stall !== 1'b1 || bubble_cnt !== 32'd1 || ex_valid !== 1'b1) begin
      failed++;
      $display("FAIL reset_precond: stall %b cnt %0d valid %b want 1 1 1", stall, bubble_cnt, ex_valid);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (act_vec() !== '0 || act_vec4() !== '0 || bubble_cnt !== 32'd0 || s_bubble_cnt !== 4'd0 || stall !== 1'b0) begin
      failed++;
      $display("FAIL reset_async: ex %h cnt %0d stall %b want all 0", act_vec(), bubble_cnt, stall);
    end
    do_reset();
  endtask

  task automatic test_passthrough();
    set_id(1'b1, 32'h0000_0100, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 32'h1234_5678, 32'h0BAD_F00D,
           32'hFFFF_FFF0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 3'b000);
    cycle("pass");
    tests++;
    if (ex_rd !== 5'd5 || ex_r1_data !== 32'h1234_5678 || ex_imm !== 32'hFFFF_FFF0 ||
        ex_reg_wr !== 1'b1 || ex_valid !== 1'b1) begin
      failed++;
      $display("FAIL pass_fields: rd %0d r1 %h imm %h reg_wr %b valid %b", ex_rd, ex_r1_data, ex_imm, ex_reg_wr, ex_valid);
    end
    set_id(1'b0, 32'h0000_0104, 5'd4, 5'd6, 5'd9, 1'b1, 1'b1, 32'hAAAA_5555, 32'h5555_AAAA,
           32'h0000_0008, 4'd7, 1'b1, 1'b1, 1'b1, 1'b1, 2'd3, 3'b101);
    cycle("invalid");
  endtask

  task automatic test_load_use();
    set_load(5'd7, 5'd1);
    cycle("lu_load");
    set_add(5'd8, 5'd3, 5'd7);
    cycle("lu_stall");
    tests++;
    if (ex_valid !== 1'b0 || ex_reg_wr !== 1'b0 || bubble_cnt !== 32'd1) begin
      failed++;
      $display("FAIL lu_bubble: valid %b reg_wr %b cnt %0d want 0 0 1", ex_valid, ex_reg_wr, bubble_cnt);
    end
    cycle("lu_release");
    tests++;
    if (ex_rd !== 5'd8 || ex_valid !== 1'b1 || ex_rs2 !== 5'd7) begin
      failed++;
      $display("FAIL lu_latched: rd %0d valid %b rs2 %0d want 8 1 7", ex_rd, ex_valid, ex_rs2);
    end
  endtask

  task automatic test_no_false_hazard();
    set_load(5'd0, 5'd1);          cycle("nf_load_x0");
    set_add(5'd4, 5'd0, 5'd0);     cycle("nf_rs_x0");
    set_load(5'd7, 5'd1);          cycle("nf_load");
    set_add(5'd4, 5'd7, 5'd2);
    id_use_rs1 = 1'b0;             cycle("nf_unused_rs1");
    set_add(5'd4, 5'd4, 5'd4);     cycle("nf_not_load_producer");
  endtask

  task automatic test_flush();
    set_load(5'd7, 5'd1);          cycle("fl_load");
    set_add(5'd3, 5'd7, 5'd7);
    flush = 1'b1;                  cycle("fl_hazard");
    flush = 1'b0;
    set_add(5'd9, 5'd2, 5'd3);
    flush = 1'b1;                  cycle("fl_plain");
    flush = 1'b0;
    set_add(5'd9, 5'd2, 5'd3);     cycle("fl_after");
  endtask

  task automatic test_x0();
    set_add(5'd0, 5'd1, 5'd2);
    cycle("x0");
    tests++;
    if (ex_reg_wr !== 1'b0 || ex_valid !== 1'b1) begin
      failed++;
      $display("FAIL x0_reg_wr: reg_wr %b valid %b want 0 1", ex_reg_wr, ex_valid);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    set_load(5'd7, 5'd7);
    for (int i = 0; i < 32; i++) cycle("sat_loop");
    tests++;
    if (s_bubble_cnt !== 4'hF || bubble_cnt !== 32'd16) begin
      failed++;
      $display("FAIL sat_full: cnt4 %h cnt %0d want f 16", s_bubble_cnt, bubble_cnt);
    end
    cycle("sat_latch");
    cycle("sat_extra");
    tests++;
    if (s_bubble_cnt !== 4'hF || bubble_cnt !== 32'd17) begin
      failed++;
      $display("FAIL sat_hold: cnt4 %h cnt %0d want f 17", s_bubble_cnt, bubble_cnt);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 80; i++) begin
      set_id(($urandom_range(0, 7) != 0), $urandom, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
             4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 3'($urandom));
      flush = ($urandom_range(0, 9) == 0);
      cycle("b2b");
    end
    id_idle();
  endtask

  initial begin
    id_idle();
    test_reset();
    test_passthrough();
    test_load_use();
    test_no_false_hazard();
    test_flush();
    test_x0();
    test_saturation();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
